// File: rtl/arb_req_agent_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the arbiter requestor agent.
//   arb_cmd_t            : default-width command payload
//   ARB_DEF_DATA_W       : default payload width
//   ARB_DEF_STARVE_LIMIT : default wait-cycle threshold for starvation
//   arb_cnt_w()          : width of an occupancy counter that can hold 0..depth
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int ARB_DEF_DATA_W       = 32;
    localparam int ARB_DEF_STARVE_LIMIT = 64;

    typedef logic [ARB_DEF_DATA_W-1:0] arb_cmd_t;

    // An occupancy count must represent "full" (== depth), hence the extra bit.
    function automatic int arb_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/arb_req_agent_if.sv
// ---------------------------------------------------------------------------
// arb_req_agent_if
// Groups the producer handshake, the arbiter req/gnt pair and the granted
// command output of one requestor agent.
//   master : producer/arbiter/consumer side (drives in_valid, in_data, gnt)
//   slave  : the agent itself (drives in_ready, req, out_valid, out_data)
// ---------------------------------------------------------------------------
interface arb_req_agent_if
    import arb_pkg::*;
#(
    parameter int DATA_W = ARB_DEF_DATA_W
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              req;
    logic              gnt;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, gnt,
        input  in_ready, req, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, gnt,
        output in_ready, req, out_valid, out_data
    );

endinterface

// File: rtl/arb_req_agent_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered occupancy count. full/empty are decoded
// from the count so no pointer-compare ambiguity exists.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write data_i at the write pointer (caller ensures !full_o)
//   data_i       : write data
//   pop_i        : advance the read pointer (caller ensures !empty_o)
//   rd_data_o    : head entry (valid while !empty_o)
//   count_o      : occupancy 0..DEPTH
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
// ---------------------------------------------------------------------------
module sync_fifo
    import arb_pkg::*;
#(
    parameter int DATA_W = ARB_DEF_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         pop_i,
    output logic [DATA_W-1:0]            rd_data_o,
    output logic [arb_cnt_w(DEPTH)-1:0]  count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = arb_cnt_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Next-state for pointers and count. DEPTH is a power of two, so the
    // pointers wrap simply by overflowing their AW bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset flushes every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array. Contents need no reset: the count gates visibility.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/arb_req_agent.sv
// ---------------------------------------------------------------------------
// arb_req_agent
// Requestor-side endpoint of a weighted round-robin arbiter. Buffers producer
// commands, requests while work is pending, pops the head on grant and shows
// it one cycle later on a registered output. Tracks how long the request has
// waited and flags starvation.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : arb_req_agent_if.slave (in_valid/in_ready/in_data,
//                req/gnt, out_valid/out_data)
//   pend_cnt   : FIFO occupancy
//   starve     : request has waited >= STARVE_LIMIT cycles
//   proto_err  : sticky protocol error
// Optional feature macro: ARB_REQ_AGENT_PROTO_CHK_EN
//   defined   -> proto_err checker and gnt X-assertion are built
//   undefined -> proto_err tied to 0
// ---------------------------------------------------------------------------
module arb_req_agent
    import arb_pkg::*;
#(
    parameter int DATA_W       = ARB_DEF_DATA_W,
    parameter int DEPTH        = 4,
    parameter int WAIT_W       = 8,
    parameter int STARVE_LIMIT = ARB_DEF_STARVE_LIMIT
) (
    input  logic                         clk,
    input  logic                         rst,
    arb_req_agent_if.slave               bus,
    output logic [arb_cnt_w(DEPTH)-1:0]  pend_cnt,
    output logic                         starve,
    output logic                         proto_err
);

    localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] STARVE_TH = WAIT_W'(STARVE_LIMIT);

    logic              fifoFull;
    logic              fifoEmpty;
    logic [DATA_W-1:0] headData;
    logic              req;
    logic              inReady;
    logic              push;
    logic              pop;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              starve_q;

    // No pop-bypass: in_ready depends only on the registered count, and req
    // is decoded from the same count so in_valid never reaches req.
    assign inReady = !fifoFull;
    assign req     = !fifoEmpty;
    assign push    = bus.in_valid & inReady;
    assign pop     = req & bus.gnt;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .data_i    (bus.in_data),
        .pop_i     (pop),
        .rd_data_o (headData),
        .count_o   (pend_cnt),
        .full_o    (fifoFull),
        .empty_o   (fifoEmpty)
    );

    // Wait counter: counts cycles of ungranted request, saturating, and
    // restarts whenever the request is served or withdrawn.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req || pop) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    // Output register, wait counter and starve flag. starve is registered
    // from the next count value so it always matches the stored counter and
    // drops in the same cycle the counter clears after a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            wait_cnt_q  <= '0;
            starve_q    <= 1'b0;
        end else begin
            out_valid_q <= pop;
            if (pop) begin
                out_data_q <= headData;
            end
            wait_cnt_q <= wait_cnt_d;
            starve_q   <= (wait_cnt_d >= STARVE_TH);
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.req       = req;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign starve        = starve_q;

`ifdef ARB_REQ_AGENT_PROTO_CHK_EN
    logic req_q;
    logic pop_q;
    logic proto_err_q;

    // Sticky protocol checker: a grant without a request, or the request
    // vanishing without having been served (cannot happen with this FIFO,
    // kept to catch future breakage).
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q       <= 1'b0;
            pop_q       <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            req_q <= req;
            pop_q <= pop;
            if ((bus.gnt && !req) || (req_q && !req && !pop_q)) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign proto_err = proto_err_q;

    gntKnownWhileReq: assert property (@(posedge clk) disable iff (rst)
        req |-> !$isunknown(bus.gnt));
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_req_agent.sv
// ---------------------------------------------------------------------------
// tb_arb_req_agent
// Directed scenarios followed by randomized traffic. A queue-based model of
// the agent predicts req/in_ready/pend_cnt/starve/proto_err each cycle and
// pushes every granted command into a scoreboard queue; an independent
// monitor pops that queue whenever out_valid is seen.
// ---------------------------------------------------------------------------
module tb_arb_req_agent;
    import arb_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 64;
    localparam int WMAX  = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] pend_cnt;
    logic       starve;
    logic       proto_err;

    arb_req_agent_if #(.DATA_W(32)) bus();

    arb_req_agent #(
        .DATA_W       (32),
        .DEPTH        (DEPTH),
        .WAIT_W       (8),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .pend_cnt  (pend_cnt),
        .starve    (starve),
        .proto_err (proto_err)
    );

    // Free-running clock; inputs change on negedge, outputs sampled 1 ns later
    // or 1 ns after posedge by the monitor.
    always #5 clk = ~clk;

    int       checks   = 0;
    int       failures = 0;
    arb_cmd_t modelQ[$];
    arb_cmd_t expQ[$];
    int       waitModel = 0;
    bit       expStarve = 1'b0;
    bit       expProto  = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus plus the model step. g requests a grant; it is
    // only applied while the model says a request is pending, unless stray
    // deliberately grants an idle requestor.
    task automatic applyStimulus(input bit v, input arb_cmd_t d, input bit g,
                                 input bit stray, input bit r);
        bit mReq, mReady, mGnt, doPush, doPop;
        @(negedge clk);
        mReq   = (modelQ.size() != 0);
        mReady = (modelQ.size() < DEPTH);
        mGnt   = g && (mReq || stray);
        rst          = r;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.gnt      = mGnt;
        #1;
        checkOutput("req",       32'(bus.req),      32'(mReq));
        checkOutput("in_ready",  32'(bus.in_ready), 32'(mReady));
        checkOutput("pend_cnt",  32'(pend_cnt),     32'(modelQ.size()));
        checkOutput("starve",    32'(starve),       32'(expStarve));
        checkOutput("proto_err", 32'(proto_err),    32'(expProto));
        if (r) begin
            modelQ.delete();
            waitModel = 0;
            expStarve = 1'b0;
            expProto  = 1'b0;
        end else begin
            doPop  = mReq && mGnt;
            doPush = v && mReady;
            if (!mReq || doPop) waitModel = 0;
            else if (waitModel < WMAX) waitModel++;
            expStarve = (waitModel >= LIMIT);
`ifdef ARB_REQ_AGENT_PROTO_CHK_EN
            if (mGnt && !mReq) expProto = 1'b1;
`endif
            if (doPop)  expQ.push_back(modelQ.pop_front());
            if (doPush) modelQ.push_back(d);
        end
    endtask

    // Monitor: every sampled cycle either consumes an expected command, or
    // checks that out_data is holding (or zero under reset).
    initial begin
        arb_cmd_t lastData;
        arb_cmd_t exp;
        lastData = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                lastData = '0;
                checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
                checkOutput("rst_out_data",  bus.out_data,       32'd0);
            end else if (bus.out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_out_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("out_data", bus.out_data, exp);
                    lastData = exp;
                end
            end else begin
                checkOutput("out_hold", bus.out_data, lastData);
            end
        end
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.gnt      = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // A, B, C with grant whenever requesting
        applyStimulus(1, 32'hA, 1, 0, 0);
        applyStimulus(1, 32'hB, 1, 0, 0);
        applyStimulus(1, 32'hC, 1, 0, 0);
        repeat (3) applyStimulus(0, '0, 1, 0, 0);

        // Fill with no grants; fifth push must be refused, then one grant
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'h100 + 32'(i), 0, 0, 0);
        applyStimulus(0, '0, 1, 0, 0);

        // Starvation: hold request ungranted for 70 cycles, then one grant
        repeat (70) applyStimulus(0, '0, 0, 0, 0);
        applyStimulus(0, '0, 1, 0, 0);
        repeat (2) applyStimulus(0, '0, 0, 0, 0);

        // Refill, then push D while full and granting the head
        repeat (2) applyStimulus(1, 32'h200, 0, 0, 0);
        applyStimulus(1, 32'hD, 1, 0, 0);
        applyStimulus(1, 32'hD, 0, 0, 0);
        repeat (5) applyStimulus(0, '0, 1, 0, 0);

        // Reset with three entries pending and a grant in the same cycle
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h300 + 32'(i), 0, 0, 0);
        applyStimulus(0, '0, 1, 0, 1);
        repeat (2) applyStimulus(0, '0, 0, 0, 0);

        // Stray grants while empty; FIFO must be unaffected afterwards
        repeat (2) applyStimulus(0, '0, 1, 1, 0);
        applyStimulus(1, 32'hE, 0, 0, 0);
        repeat (3) applyStimulus(0, '0, 1, 0, 0);

        // Random traffic with occasional stray grants and resets
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(bit'($urandom_range(0, 1)), arb_cmd_t'($urandom),
                          $urandom_range(0, 99) < 60,
                          $urandom_range(0, 99) < 3,
                          $urandom_range(0, 199) == 0);
        end
        // Rarely granted traffic so starvation and saturation get exercised
        for (int i = 0; i < 600; i++) begin
            applyStimulus(bit'($urandom_range(0, 1)), arb_cmd_t'($urandom),
                          $urandom_range(0, 99) == 0, 1'b0, 1'b0);
        end

        // Drain and confirm every granted command was presented
        repeat (6) applyStimulus(0, '0, 1, 0, 0);
        repeat (2) applyStimulus(0, '0, 0, 0, 0);
        checkOutput("missing_out_valid", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
